test_scheduler: RTL and testbench
=================================

TEST_SCHEDULER -- requirements
Module: test_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_DUT, default 5: number of DUTs in the test environment.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535: per-DUT wait limit in clock cycles, minimum 2.
REQ-003 The block SHALL have parameter SEL_WIDTH, default $clog2(NUM_DUT)+1: DUT select width, matching the test-environment select bus.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: CLK_SYS in 1, system clock; RST in 1, synchronous active-high reset.
REQ-005 The block SHALL have port BATCH_START, in, 1: one-cycle request to run a batch.
REQ-006 The block SHALL have port ABORT, in, 1: terminate the running batch.
REQ-007 The block SHALL have port DUT_MASK, in, NUM_DUT: DUTs to test, sampled at batch accept.
REQ-008 The block SHALL have port DUT_RDY, in, 1: ready flag of the selected DUT, high when idle or finished.
REQ-009 The block SHALL have port DUT_SEL, out, SEL_WIDTH: DUT select.
REQ-010 The block SHALL have port DUT_DO_TEST, out, 1: one-cycle test-start pulse.
REQ-011 The block SHALL have port BUSY, out, 1: high while a batch runs.
REQ-012 The block SHALL have port DONE, out, 1: one-cycle batch-end pulse.
REQ-013 The block SHALL have port ABORTED, out, 1: last batch ended by ABORT.
REQ-014 The block SHALL have port PASS_MASK, out, NUM_DUT: DUTs that completed.
REQ-015 The block SHALL have port TIMEOUT_MASK, out, NUM_DUT: DUTs that timed out.

Function
REQ-016 All outputs SHALL be registered; the FSM SHALL have states IDLE, SCAN, SELECT, START, WAIT_ACK, WAIT_DONE, FINISH.
REQ-017 In IDLE with BATCH_START=1 and ABORT=0, the block SHALL latch DUT_MASK, clear PASS_MASK, TIMEOUT_MASK and ABORTED, set index=0, and go to SCAN.
REQ-018 BATCH_START outside IDLE SHALL be ignored; ABORT in IDLE SHALL be ignored, and BATCH_START with ABORT in IDLE SHALL NOT start a batch.
REQ-019 SCAN SHALL examine one index per cycle: index==NUM_DUT goes to FINISH; latched mask bit set loads DUT_SEL<=index and goes to SELECT; otherwise index increments and the FSM stays in SCAN.
REQ-020 SELECT SHALL last exactly one cycle (select settle) and then go to START.
REQ-021 START SHALL drive DUT_DO_TEST=1 for exactly one cycle, clear the wait counter and go to WAIT_ACK; DUT_DO_TEST SHALL be 0 in all other states.
REQ-022 In WAIT_ACK, DUT_RDY=0 SHALL move the FSM to WAIT_DONE without clearing the wait counter.
REQ-023 In WAIT_DONE, DUT_RDY=1 SHALL set PASS_MASK[index], increment index and go to SCAN.
REQ-024 The wait counter SHALL increment once per cycle in WAIT_ACK and WAIT_DONE, saturating at TIMEOUT_CYCLES-1.
REQ-025 If the wait counter equals TIMEOUT_CYCLES-1 in WAIT_ACK or WAIT_DONE and the exit condition is not met that cycle, the block SHALL set TIMEOUT_MASK[index], increment index and go to SCAN.
REQ-026 When the exit condition and timeout coincide, the exit condition SHALL win.
REQ-027 For any index, PASS_MASK and TIMEOUT_MASK SHALL never both be set.
REQ-028 FINISH SHALL drive DONE=1 for one cycle and then return to IDLE.
REQ-029 BUSY SHALL be 1 in every state except IDLE.
REQ-030 ABORT=1 in any state other than IDLE or FINISH SHALL go to FINISH next cycle and set ABORTED=1.
REQ-031 On ABORT, mask bits already recorded SHALL be kept, and the aborted DUT SHALL be marked in neither mask.
REQ-032 PASS_MASK, TIMEOUT_MASK, ABORTED and DUT_SEL SHALL hold their values after DONE until the next accepted batch.
REQ-033 DUTs SHALL be tested strictly in ascending index order, one at a time.

Reset
REQ-034 While RST=1 at a rising CLK_SYS edge, the block SHALL enter IDLE with DUT_SEL=0, DUT_DO_TEST=0, BUSY=0, DONE=0, ABORTED=0, PASS_MASK=0, TIMEOUT_MASK=0, index=0 and wait counter=0.
REQ-035 RST mid-batch SHALL abort without a DONE pulse, and the first cycle after reset release SHALL accept BATCH_START.

Verification
REQ-036 Bench check, NUM_DUT=5, mask 5'b10101, each DUT drops RDY 2 cycles after DO_TEST and raises it 10 cycles later: DO_TEST pulses with DUT_SEL=0,2,4 in order; DONE once; PASS_MASK=5'b10101; TIMEOUT_MASK=0.
REQ-037 Bench check, mask 0: no DO_TEST pulse; DONE within NUM_DUT+3 cycles of BATCH_START; both masks 0; BUSY high until DONE.
REQ-038 Bench check, TIMEOUT_CYCLES=16, mask 5'b00011, DUT0 holds RDY=1 permanently, DUT1 normal: TIMEOUT_MASK=5'b00001; PASS_MASK=5'b00010; DUT1 started exactly 16 wait cycles after DUT0 entered WAIT_ACK.
REQ-039 Bench check, ABORT asserted during DUT2 WAIT_DONE, mask 5'b11111: DONE next cycle+1; ABORTED=1; PASS_MASK=5'b00011; DUT3 and DUT4 never started.
REQ-040 Bench check, BATCH_START re-pulsed while BUSY, then RST mid-batch: the repeat start is ignored; after RST all outputs are 0, no DONE, and a new BATCH_START is accepted one cycle after release.
REQ-041 Bench check, timeout cycle coincident with DUT_RDY rising in WAIT_DONE: PASS bit set and TIMEOUT bit clear.

Source files
------------

// File: rtl/test_scheduler.sv
// Batch test scheduler: walks a latched DUT mask in ascending order, starts each
// selected DUT, waits for its ready handshake with a per-DUT timeout, and records
// which DUTs completed and which timed out. All outputs are registered.
module test_scheduler #(
    parameter int NUM_DUT        = 5,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SEL_WIDTH      = $clog2(NUM_DUT) + 1
) (
    input  logic                 CLK_SYS,
    input  logic                 RST,
    input  logic                 BATCH_START,
    input  logic                 ABORT,
    input  logic [NUM_DUT-1:0]   DUT_MASK,
    input  logic                 DUT_RDY,
    output logic [SEL_WIDTH-1:0] DUT_SEL,
    output logic                 DUT_DO_TEST,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ABORTED,
    output logic [NUM_DUT-1:0]   PASS_MASK,
    output logic [NUM_DUT-1:0]   TIMEOUT_MASK
);

    // Index must reach NUM_DUT itself, which is the "scan finished" value.
    localparam int IDX_W = $clog2(NUM_DUT + 1);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_DUT);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SELECT,
        START,
        WAIT_ACK,
        WAIT_DONE,
        FINISH
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic [NUM_DUT-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 do_test_q, do_test_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic [NUM_DUT-1:0]   pass_q, pass_d;
    logic [NUM_DUT-1:0]   tmo_q, tmo_d;

    logic                 timeout_hit;
    logic [CNT_W-1:0]     cnt_inc;

    // Next-state, bookkeeping and registered-output values for the scheduler FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        index_d   = index_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        pass_d    = pass_q;
        tmo_d     = tmo_q;
        aborted_d = aborted_q;

        timeout_hit = (cnt_q == CNT_LAST);
        // Counter saturates at its last value rather than wrapping.
        cnt_inc     = timeout_hit ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (BATCH_START && !ABORT) begin
                    mask_d    = DUT_MASK;
                    pass_d    = '0;
                    tmo_d     = '0;
                    aborted_d = 1'b0;
                    index_d   = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (index_q == IDX_END) begin
                    state_d = FINISH;
                end else if (mask_q[index_q]) begin
                    sel_d   = SEL_WIDTH'(index_q);
                    state_d = SELECT;
                end else begin
                    index_d = index_q + IDX_W'(1);
                end
            end
            SELECT: begin
                // One idle cycle lets the select bus settle before the start pulse.
                state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                cnt_d = cnt_inc;
                // Exit condition is tested before the timeout so it wins a tie.
                if (!DUT_RDY) begin
                    state_d = WAIT_DONE;
                end else if (timeout_hit) begin
                    tmo_d[index_q] = 1'b1;
                    index_d        = index_q + IDX_W'(1);
                    state_d        = SCAN;
                end
            end
            WAIT_DONE: begin
                cnt_d = cnt_inc;
                if (DUT_RDY) begin
                    pass_d[index_q] = 1'b1;
                    index_d         = index_q + IDX_W'(1);
                    state_d         = SCAN;
                end else if (timeout_hit) begin
                    tmo_d[index_q] = 1'b1;
                    index_d        = index_q + IDX_W'(1);
                    state_d        = SCAN;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything mid-batch; the DUT in flight is recorded in
        // neither mask, while results already collected are kept.
        if (ABORT && (state_q != IDLE) && (state_q != FINISH)) begin
            state_d   = FINISH;
            aborted_d = 1'b1;
            pass_d    = pass_q;
            tmo_d     = tmo_q;
            index_d   = index_q;
        end

        // Outputs are registered copies of the state being entered, so they line
        // up exactly with the state they describe.
        do_test_d = (state_d == START);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == FINISH);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge CLK_SYS) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (RST) begin
            state_q   <= IDLE;
            index_q   <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            sel_q     <= '0;
            do_test_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            pass_q    <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            do_test_q <= do_test_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            pass_q    <= pass_d;
            tmo_q     <= tmo_d;
        end
    end

    assign DUT_SEL      = sel_q;
    assign DUT_DO_TEST  = do_test_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign ABORTED      = aborted_q;
    assign PASS_MASK    = pass_q;
    assign TIMEOUT_MASK = tmo_q;

endmodule

// File: tb/tb_test_scheduler.sv
// Self-checking bench for test_scheduler: a behavioural DUT-ready model, a
// table of whole-batch vectors, and hand-written abort / reset sequences.
module tb_test_scheduler;

    localparam int NUM_DUT = 5;
    localparam int TMO     = 16;
    localparam int SEL_W   = $clog2(NUM_DUT) + 1;
    localparam int BUDGET  = 2000;

    logic               CLK_SYS = 1'b0;
    logic               RST = 1'b1;
    logic               BATCH_START = 1'b0;
    logic               ABORT = 1'b0;
    logic [NUM_DUT-1:0] DUT_MASK = '0;
    logic               DUT_RDY;
    logic [SEL_W-1:0]   DUT_SEL;
    logic               DUT_DO_TEST;
    logic               BUSY;
    logic               DONE;
    logic               ABORTED;
    logic [NUM_DUT-1:0] PASS_MASK;
    logic [NUM_DUT-1:0] TIMEOUT_MASK;

    test_scheduler #(
        .NUM_DUT        (NUM_DUT),
        .TIMEOUT_CYCLES (TMO),
        .SEL_WIDTH      (SEL_W)
    ) dut (
        .CLK_SYS      (CLK_SYS),
        .RST          (RST),
        .BATCH_START  (BATCH_START),
        .ABORT        (ABORT),
        .DUT_MASK     (DUT_MASK),
        .DUT_RDY      (DUT_RDY),
        .DUT_SEL      (DUT_SEL),
        .DUT_DO_TEST  (DUT_DO_TEST),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .ABORTED      (ABORTED),
        .PASS_MASK    (PASS_MASK),
        .TIMEOUT_MASK (TIMEOUT_MASK)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DUT model settings: RDY stays high for drop_c cycles after the start
    // pulse cycle, low for low_c cycles, then high. hang_c DUTs never drop;
    // stuck_c DUTs drop and never rise.
    int               drop_c = 2;
    int               low_c  = 10;
    logic [NUM_DUT-1:0] hang_c  = '0;
    logic [NUM_DUT-1:0] stuck_c = '0;

    int starts[$];
    int start_cyc[$];
    int done_cnt = 0;
    int cyc = 0;

    // Behavioural DUT and monitor, updated just after each rising edge.
    initial begin
        int  k;
        int  cur;
        bit  active;
        k = 0; cur = 0; active = 0;
        DUT_RDY = 1'b1;
        forever begin
            @(posedge CLK_SYS);
            #1;
            cyc++;
            if (RST) begin
                active = 0;
            end else if (DUT_DO_TEST) begin
                cur    = int'(DUT_SEL);
                k      = 0;
                active = 1;
                starts.push_back(cur);
                start_cyc.push_back(cyc);
            end else if (active) begin
                k++;
            end
            if (DONE) begin
                done_cnt++;
                active = 0;
            end
            if (!active || hang_c[cur]) DUT_RDY = 1'b1;
            else if (k < drop_c)        DUT_RDY = 1'b1;
            else if (stuck_c[cur] || k < drop_c + low_c) DUT_RDY = 1'b0;
            else                        DUT_RDY = 1'b1;
        end
    end

    task automatic start_batch(input logic [NUM_DUT-1:0] mask);
        starts.delete();
        start_cyc.delete();
        done_cnt = 0;
        @(negedge CLK_SYS);
        DUT_MASK    = mask;
        BATCH_START = 1'b1;
        @(negedge CLK_SYS);
        BATCH_START = 1'b0;
    endtask

    // Returns the number of cycles from batch accept to DONE and whether BUSY
    // held high throughout.
    task automatic wait_done(output int n, output bit busy_ok);
        n = 1;
        busy_ok = 1;
        while (!DONE && n < BUDGET) begin
            if (!BUSY) busy_ok = 0;
            @(negedge CLK_SYS);
            n++;
        end
        if (!BUSY) busy_ok = 0;
        check("done_seen", 32'(DONE), 32'd1);
    endtask

    task automatic wait_starts(input int cnt);
        int n;
        n = 0;
        while (starts.size() < cnt && n < BUDGET) begin
            @(negedge CLK_SYS);
            n++;
        end
        check("starts_reached", 32'(starts.size() >= cnt), 32'd1);
    endtask

    typedef struct {
        logic [NUM_DUT-1:0] mask;
        int                 drop;
        int                 low;
        logic [NUM_DUT-1:0] hang;
        logic [NUM_DUT-1:0] stuck;
        logic [NUM_DUT-1:0] exp_pass;
        logic [NUM_DUT-1:0] exp_tmo;
        int                 exp_gap;   // cycles between first two starts, 0 = skip
    } vec_t;

    vec_t vecs[6];

    initial begin
        int  n;
        bit  busy_ok;
        int  exp_sel[$];
        logic [NUM_DUT-1:0] m;

        // mask, drop, low, hang, stuck, pass, timeout, gap
        vecs[0] = '{5'b10101, 2, 10, 5'b00000, 5'b00000, 5'b10101, 5'b00000, 16};
        vecs[1] = '{5'b00000, 2, 10, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 0};
        vecs[2] = '{5'b00011, 2, 10, 5'b00001, 5'b00000, 5'b00010, 5'b00001, 19};
        vecs[3] = '{5'b11111, 1, 15, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 19};
        vecs[4] = '{5'b01000, 1, 16, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 0};
        vecs[5] = '{5'b10001, 2, 10, 5'b00000, 5'b00001, 5'b10000, 5'b00001, 22};

        // Reset state.
        repeat (3) @(negedge CLK_SYS);
        check("reset_outputs",
              32'({DUT_SEL, DUT_DO_TEST, BUSY, DONE, ABORTED, PASS_MASK, TIMEOUT_MASK}), 32'd0);
        RST = 1'b0;

        // BATCH_START together with ABORT in IDLE must not start a batch.
        @(negedge CLK_SYS);
        DUT_MASK    = 5'b11111;
        BATCH_START = 1'b1;
        ABORT       = 1'b1;
        @(negedge CLK_SYS);
        BATCH_START = 1'b0;
        check("start_with_abort_busy", 32'(BUSY), 32'd0);
        @(negedge CLK_SYS);
        ABORT = 1'b0;
        check("abort_in_idle", 32'({BUSY, ABORTED}), 32'd0);

        // Table-driven whole batches.
        foreach (vecs[i]) begin
            drop_c  = vecs[i].drop;
            low_c   = vecs[i].low;
            hang_c  = vecs[i].hang;
            stuck_c = vecs[i].stuck;
            start_batch(vecs[i].mask);
            wait_done(n, busy_ok);
            check($sformatf("v%0d_busy", i), 32'(busy_ok), 32'd1);
            if (vecs[i].mask == '0)
                check("mask0_latency_ok", 32'(n <= NUM_DUT + 3), 32'd1);
            repeat (2) @(negedge CLK_SYS);
            check($sformatf("v%0d_idle", i), 32'({BUSY, DONE}), 32'd0);
            check($sformatf("v%0d_done_cnt", i), 32'(done_cnt), 32'd1);
            check($sformatf("v%0d_pass", i), 32'(PASS_MASK), 32'(vecs[i].exp_pass));
            check($sformatf("v%0d_tmo", i), 32'(TIMEOUT_MASK), 32'(vecs[i].exp_tmo));
            check($sformatf("v%0d_aborted", i), 32'(ABORTED), 32'd0);
            exp_sel.delete();
            m = vecs[i].mask;
            for (int b = 0; b < NUM_DUT; b++) if (m[b]) exp_sel.push_back(b);
            check($sformatf("v%0d_nstarts", i), 32'(starts.size()), 32'(exp_sel.size()));
            for (int j = 0; j < exp_sel.size() && j < starts.size(); j++)
                check($sformatf("v%0d_sel%0d", i, j), 32'(starts[j]), 32'(exp_sel[j]));
            if (vecs[i].exp_gap != 0 && start_cyc.size() >= 2)
                check($sformatf("v%0d_gap", i), 32'(start_cyc[1] - start_cyc[0]),
                      32'(vecs[i].exp_gap));
        end

        // Abort during DUT2 WAIT_DONE.
        drop_c = 2; low_c = 10; hang_c = '0; stuck_c = '0;
        start_batch(5'b11111);
        wait_starts(3);
        repeat (4) @(negedge CLK_SYS);
        ABORT = 1'b1;
        @(negedge CLK_SYS);
        ABORT = 1'b0;
        check("abort_done_next", 32'(DONE), 32'd1);
        check("abort_flag", 32'(ABORTED), 32'd1);
        check("abort_pass", 32'(PASS_MASK), 32'h03);
        check("abort_tmo", 32'(TIMEOUT_MASK), 32'h00);
        repeat (20) @(negedge CLK_SYS);
        check("abort_nstarts", 32'(starts.size()), 32'd3);
        check("abort_done_cnt", 32'(done_cnt), 32'd1);
        check("abort_hold", 32'({BUSY, ABORTED, PASS_MASK}), 32'({1'b0, 1'b1, 5'b00011}));

        // Repeat start while busy is ignored, then reset mid-batch.
        start_batch(5'b11111);
        wait_starts(2);
        @(negedge CLK_SYS);
        BATCH_START = 1'b1;
        @(negedge CLK_SYS);
        BATCH_START = 1'b0;
        wait_starts(3);
        if (starts.size() >= 3) check("restart_ignored_sel", 32'(starts[2]), 32'd2);
        check("restart_ignored_pass", 32'(PASS_MASK), 32'h03);
        repeat (3) @(negedge CLK_SYS);
        RST = 1'b1;
        @(negedge CLK_SYS);
        check("rst_mid_outputs",
              32'({DUT_SEL, DUT_DO_TEST, BUSY, DONE, ABORTED, PASS_MASK, TIMEOUT_MASK}), 32'd0);
        check("rst_mid_no_done", 32'(done_cnt), 32'd0);
        starts.delete();
        start_cyc.delete();
        RST         = 1'b0;
        DUT_MASK    = 5'b00001;
        BATCH_START = 1'b1;
        @(negedge CLK_SYS);
        BATCH_START = 1'b0;
        check("post_rst_accept", 32'(BUSY), 32'd1);
        wait_done(n, busy_ok);
        repeat (2) @(negedge CLK_SYS);
        check("post_rst_pass", 32'(PASS_MASK), 32'h01);
        check("post_rst_done_cnt", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
